// File: rtl/branch_sequencer.sv
// Purpose: sequences the T3..T6 control steps of a conditional branch and keeps branch/taken statistics.
// Latency: strobes in cycles 1..4 after the accepting edge, done in cycle 5, ready again in cycle 6; illegal opcode done in cycle 1.
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise, abort cancels an active sequence.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10010
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        taken,
  output logic [3:0]  C2_out,
  output logic        Gra,
  output logic        Rout,
  output logic        CONin,
  output logic        PCout,
  output logic        Yin,
  output logic        Cout,
  output logic        ADD,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;

  // Only the opcode and C2 fields matter here; the rest of IR is carried for the datapath.
  logic ir_unused;
  assign ir_unused = ^{IR[26:23], IR[18:0]};

  // Sequence state, latched instruction fields, status flags and saturating statistics.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state        <= S_IDLE;
      illegal      <= 1'b0;
      taken        <= 1'b0;
      C2_out       <= 4'h0;
      branch_count <= 16'h0000;
      taken_count  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          // start outranks abort here; abort has nothing to cancel in IDLE
          if (start) begin
            if (IR[31:27] == BR_OPCODE) begin
              state   <= S_T3;
              C2_out  <= IR[22:19];
              illegal <= 1'b0;
              taken   <= 1'b0;
            end else begin
              state   <= S_ERR;
              illegal <= 1'b1;
            end
          end
        end
        S_T3: state <= abort ? S_IDLE : S_T4;
        S_T4: state <= abort ? S_IDLE : S_T5;
        S_T5: state <= abort ? S_IDLE : S_T6;
        S_T6: begin
          if (abort) begin
            // a cancelled branch must not be counted nor change the taken flag
            state <= S_IDLE;
          end else begin
            state <= S_DONE;
            taken <= CON;
            if (branch_count != 16'hFFFF) begin
              branch_count <= branch_count + 16'd1;
            end
            if (CON && (taken_count != 16'hFFFF)) begin
              taken_count <= taken_count + 16'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the step strobes; abort blanks every strobe in the cycle it is seen.
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE) || (state == S_ERR);
    Gra     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    PCout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ADD     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    if (!abort) begin
      case (state)
        S_T3: begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          CONin = 1'b1;
        end
        S_T4: begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
        S_T5: begin
          Cout = 1'b1;
          ADD  = 1'b1;
          Zin  = 1'b1;
        end
        S_T6: begin
          Zlowout = 1'b1;
          PCin    = CON;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Purpose: directed and randomized checking of branch_sequencer against a per-transaction cycle model.
// Latency: inputs change at the falling edge, outputs are sampled 1 time unit later.
// Backpressure: not applicable; the bench drives start/abort freely.
module tb_branch_sequencer;

  localparam logic [4:0] BR = 5'b10010;

  logic        Clock;
  logic        Clear;
  logic        start;
  logic        abort;
  logic [31:0] IR;
  logic        CON;
  logic        busy, done, illegal, taken;
  logic [3:0]  C2_out;
  logic        Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
  logic [15:0] branch_count, taken_count;

  branch_sequencer #(.BR_OPCODE(BR)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .abort(abort), .IR(IR), .CON(CON),
    .busy(busy), .done(done), .illegal(illegal), .taken(taken), .C2_out(C2_out),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin),
    .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // strobe groups in bit order {Gra,Rout,CONin,PCout,Yin,Cout,ADD,Zin,Zlowout,PCin}
  logic [9:0] strobes;
  assign strobes = {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin};

  int checks = 0;
  int passes = 0;

  // reference model state: what the architecture-visible results should be
  logic [3:0]  m_c2;
  logic        m_illegal, m_taken;
  int unsigned m_branches, m_takens;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] sat16(input int unsigned n);
    return (n > 32'd65535) ? 16'hFFFF : n[15:0];
  endfunction

  // which strobes a branch step should show, by cycle number after acceptance
  function automatic logic [9:0] step_strobes(input int c, input logic con_v);
    case (c)
      1: return 10'b1110000000;
      2: return 10'b0001100000;
      3: return 10'b0000011100;
      4: return {9'b000000001, con_v};
      default: return 10'b0;
    endcase
  endfunction

  task automatic chk_all(input string tag, input logic e_busy, input logic e_done, input logic [9:0] e_str);
    chk({tag, ".busy"},    32'(busy),         32'(e_busy));
    chk({tag, ".done"},    32'(done),         32'(e_done));
    chk({tag, ".strobes"}, 32'(strobes),      32'(e_str));
    chk({tag, ".illegal"}, 32'(illegal),      32'(m_illegal));
    chk({tag, ".taken"},   32'(taken),        32'(m_taken));
    chk({tag, ".C2_out"},  32'(C2_out),       32'(m_c2));
    chk({tag, ".brcnt"},   32'(branch_count), 32'(sat16(m_branches)));
    chk({tag, ".tkcnt"},   32'(taken_count),  32'(sat16(m_takens)));
  endtask

  // one instruction handoff; abort_at/glitch_at name the cycle (1..) to pulse abort/start, 0 for never
  task automatic run_txn(input string tag, input logic [31:0] ir, input logic con_v,
                         input int abort_at, input int glitch_at);
    logic        legal;
    logic [31:0] r;
    legal = (ir[31:27] == BR);
    @(negedge Clock);
    IR    = ir;
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    CON   = 1'($urandom_range(0, 1));
    if (legal) begin
      m_c2      = ir[22:19];
      m_illegal = 1'b0;
      m_taken   = 1'b0;
    end else begin
      m_illegal = 1'b1;
    end
    if (!legal) begin
      @(negedge Clock);
      start = 1'b0;
      abort = 1'($urandom_range(0, 1));
      #1 chk_all({tag, ".err1"}, 1'b1, 1'b1, 10'b0);
      @(negedge Clock);
      abort = 1'b0;
      #1 chk_all({tag, ".err2"}, 1'b0, 1'b0, 10'b0);
      return;
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clock);
      r     = $urandom;
      start = (c == glitch_at) && (c <= 5) && (abort_at == 0 || c <= abort_at);
      IR    = start ? {BR, r[26:0]} : ir;
      if (abort_at != 0 && c == abort_at + 1) begin
        start = 1'b0;
        abort = 1'b0;
        #1 chk_all($sformatf("%s.idle_after_abort", tag), 1'b0, 1'b0, 10'b0);
        return;
      end
      abort = (c == abort_at) || (c >= 5 && r[31]);
      CON   = (c == 4) ? con_v : r[30];
      if (c == 5) begin
        m_taken = con_v;
        m_branches++;
        if (con_v) m_takens++;
      end
      #1;
      if (c == abort_at)
        chk_all($sformatf("%s.c%0d_abort", tag, c), 1'b1, 1'b0, 10'b0);
      else
        chk_all($sformatf("%s.c%0d", tag, c), (c <= 5), (c == 5), step_strobes(c, con_v));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    Clear = 1'b1; start = 1'b0; abort = 1'b0; IR = 32'h0; CON = 1'b0;
    m_c2 = 4'h0; m_illegal = 1'b0; m_taken = 1'b0; m_branches = 0; m_takens = 0;
    repeat (2) @(negedge Clock);
    #1 chk_all("reset", 1'b0, 1'b0, 10'b0);
    Clear = 1'b0;

    // taken branch, C2=0
    run_txn("taken", 32'h9000_0000, 1'b1, 0, 0);
    // not-taken branch, C2=1
    run_txn("nottaken", 32'h9008_0000, 1'b0, 0, 0);
    chk("nottaken.c2", 32'(C2_out), 32'h1);
    // illegal opcode
    run_txn("illegal", 32'h1800_0000, 1'b0, 0, 0);
    // abort in T5 with a stray start in T4
    run_txn("abort_t5", 32'h9030_0000, 1'b1, 3, 2);

    // Clear held two cycles starting mid-T4
    @(negedge Clock);
    IR = 32'h9000_0000; start = 1'b1; abort = 1'b0;
    m_c2 = 4'h0; m_illegal = 1'b0; m_taken = 1'b0;
    @(negedge Clock);
    start = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    #1 chk("clr.t4_still_driving", 32'(strobes), 32'(10'b0001100000));
    m_c2 = 4'h0; m_illegal = 1'b0; m_taken = 1'b0; m_branches = 0; m_takens = 0;
    @(negedge Clock);
    #1 chk_all("clr.held", 1'b0, 1'b0, 10'b0);
    @(negedge Clock);
    Clear = 1'b0;
    #1 chk_all("clr.released", 1'b0, 1'b0, 10'b0);
    run_txn("after_clear", 32'h9048_0000, 1'b1, 0, 0);

    // randomized mix of legal/illegal opcodes, aborts and stray starts
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      if (r[1:0] != 2'b00) begin
        op = BR;
      end else begin
        op = 5'($urandom_range(0, 31));
        if (op == BR) op = op ^ 5'b00001;
      end
      run_txn($sformatf("rnd%0d", i), {op, r[28:2]}, r[29],
              (r[31:30] == 2'b00) ? int'($urandom_range(1, 4)) : 0,
              int'($urandom_range(0, 5)));
    end

    // saturation: preload both counters just below the ceiling
    @(negedge Clock);
    force dut.branch_count = 16'hFFFE;
    force dut.taken_count  = 16'hFFFE;
    #1;
    release dut.branch_count;
    release dut.taken_count;
    m_branches = 32'hFFFE;
    m_takens   = 32'hFFFE;
    run_txn("sat1", 32'h9000_0000, 1'b1, 0, 0);
    run_txn("sat2", 32'h9000_0000, 1'b1, 0, 0);
    run_txn("sat3", 32'h9008_0000, 1'b1, 0, 0);
    run_txn("sat4", 32'h9008_0000, 1'b0, 0, 0);
    chk("sat.brcnt_final", 32'(branch_count), 32'h0000_FFFF);
    chk("sat.tkcnt_final", 32'(taken_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
